// File: rtl/prog_loader_if.sv
// Host-to-loader byte port. A byte transfers on a rising clock edge where
// byte_valid && byte_ready; byte_ready never depends on byte_valid.
interface prog_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/prog_loader.sv
// Serial programming transmitter: streams PROG_BITS image bits LSB-first from
// host bytes, double-buffered through a holding register so the stream is gap-free.
module prog_loader #(
    parameter int PROG_BITS = 208
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    prog_loader_if.slave  bus,
    output logic          prog_enable,
    output logic          prog_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    state_dbg
);
    localparam int BYTE_COUNT = (PROG_BITS + 7) / 8;
    localparam int BCW = $clog2(BYTE_COUNT + 1);
    localparam int BTW = $clog2(PROG_BITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [7:0]     sr, hr;
    logic           sr_valid, hr_valid;
    logic [2:0]     bit_idx;
    logic [BCW-1:0] byte_cnt;
    logic [BTW-1:0] bit_cnt;

    logic byte_ready;
    logic accept;
    logic prefill_load;
    logic shift_en;
    logic finish;
    logic underrun;
    logic reload;

    // Ready is a function of registered state (and abort) only.
    assign byte_ready = ((state == PREFILL) || (state == SHIFT)) && !hr_valid &&
                        (byte_cnt < BCW'(BYTE_COUNT)) && !abort;
    assign bus.byte_ready = byte_ready;
    assign accept    = bus.byte_valid && byte_ready;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clock) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        prefill_load = 1'b0;
        shift_en     = 1'b0;
        finish       = 1'b0;
        underrun     = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) state_next = PREFILL;
                PREFILL: begin
                    prefill_load = !sr_valid && hr_valid;
                    if (sr_valid && (hr_valid || byte_cnt == BCW'(BYTE_COUNT)))
                        state_next = SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt == BTW'(PROG_BITS)) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else if (!sr_valid) begin
                        // SR ran dry at the previous reload point with bits still owed.
                        underrun   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        shift_en   = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Reload only when this is the 8th bit of SR and the image is not yet complete.
    assign reload = shift_en && (bit_idx == 3'd7) && (bit_cnt != BTW'(PROG_BITS - 1));

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            prog_enable <= 1'b0;
            prog_data   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            sr          <= '0;
            hr          <= '0;
            sr_valid    <= 1'b0;
            hr_valid    <= 1'b0;
            bit_idx     <= '0;
            byte_cnt    <= '0;
            bit_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                prog_enable <= 1'b0;
                prog_data   <= 1'b0;
                sr_valid    <= 1'b0;
                hr_valid    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        prog_enable <= 1'b0;
                        prog_data   <= 1'b0;
                        if (start) begin
                            error    <= 1'b0;
                            sr_valid <= 1'b0;
                            hr_valid <= 1'b0;
                            bit_idx  <= '0;
                            byte_cnt <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                    PREFILL: begin
                        if (prefill_load) begin
                            sr       <= hr;
                            sr_valid <= 1'b1;
                            hr_valid <= 1'b0;
                            bit_idx  <= '0;
                        end
                        if (accept) begin
                            hr       <= bus.byte_data;
                            hr_valid <= 1'b1;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (finish || underrun) begin
                            prog_enable <= 1'b0;
                            prog_data   <= 1'b0;
                            sr_valid    <= 1'b0;
                            hr_valid    <= 1'b0;
                            done        <= finish;
                            if (underrun) error <= 1'b1;
                        end else begin
                            prog_enable <= 1'b1;
                            prog_data   <= sr[0];
                            bit_cnt     <= bit_cnt + 1'b1;
                            if (reload) begin
                                bit_idx <= '0;
                                if (hr_valid) begin
                                    sr       <= hr;
                                    hr_valid <= 1'b0;
                                end else begin
                                    sr_valid <= 1'b0;
                                end
                            end else begin
                                sr      <= {1'b0, sr[7:1]};
                                bit_idx <= bit_idx + 1'b1;
                            end
                            if (accept) begin
                                hr       <= bus.byte_data;
                                hr_valid <= 1'b1;
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        prog_enable <= 1'b0;
                        prog_data   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: full 208-bit image instance plus a 13-bit instance
// for the partial-last-byte case; stream bits are checked against a queue.
module tb_prog_loader;
    localparam int PB   = 208;
    localparam int PB13 = 13;
    localparam int W    = 1;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    logic prog_enable, prog_data, busy, done, error;
    logic [1:0] state_dbg;

    logic start13 = 1'b0, abort13 = 1'b0;
    logic pe13, pd13, busy13, done13, error13;
    logic [1:0] state13;

    prog_loader_if bif();
    prog_loader_if bif13();

    prog_loader #(.PROG_BITS(PB)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .abort(abort), .bus(bif),
        .prog_enable(prog_enable), .prog_data(prog_data), .busy(busy),
        .done(done), .error(error), .state_dbg(state_dbg)
    );

    prog_loader #(.PROG_BITS(PB13)) dut13 (
        .clock(clock), .rst_n(rst_n), .start(start13), .abort(abort13), .bus(bif13),
        .prog_enable(pe13), .prog_data(pd13), .busy(busy13),
        .done(done13), .error(error13), .state_dbg(state13)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp13_q[$];
    int en_cnt = 0, rises = 0, done_cnt = 0;
    int en13 = 0, done13_cnt = 0;
    logic prev_pe = 1'b0;
    logic stop_host = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stream monitors sample away from the active edge.
    always @(negedge clock) begin
        if (prog_enable) begin
            en_cnt++;
            if (!prev_pe) rises++;
            if (exp_q.size() == 0) check("extra_bit", 32'd1, 32'd0);
            else check("stream_bit", 32'(prog_data), 32'(exp_q.pop_front()));
        end
        prev_pe = prog_enable;
        if (done) done_cnt++;
    end

    always @(negedge clock) begin
        if (pe13) begin
            en13++;
            if (exp13_q.size() == 0) check("extra_bit13", 32'd1, 32'd0);
            else check("stream_bit13", 32'(pd13), 32'(exp13_q.pop_front()));
        end
        if (done13) done13_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Host driver: byte i carries value i+1; mode 1 adds idle cycles.
    task automatic feed(input int nbytes, input int mode);
        logic [7:0] b;
        int gap, t;
        logic ok;
        for (int i = 0; i < nbytes && !stop_host; i++) begin
            b = 8'(i + 1);
            gap = (mode == 1) ? ((i < 2) ? 5 : int'($urandom_range(0, 3))) : 0;
            for (int j = 0; j < 8; j++)
                if (i * 8 + j < PB) exp_q.push_back(b[j]);
            bif.byte_valid = 1'b0;
            repeat (gap) tick();
            bif.byte_data  = b;
            bif.byte_valid = 1'b1;
            t = 0;
            while (!stop_host) begin
                ok = bif.byte_ready;
                tick();
                if (ok) break;
                t++;
                if (t > 60) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    stop_host = 1'b1;
                end
            end
        end
        bif.byte_valid = 1'b0;
    endtask

    task automatic begin_run();
        en_cnt = 0; rises = 0; done_cnt = 0;
        exp_q.delete();
        stop_host = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int t;
        t = 0;
        while (busy && t < limit) begin
            tick();
            t++;
        end
        if (busy) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
        repeat (2) tick();
    endtask

    task automatic wait_bits(input int n);
        for (int t = 0; t < 2000 && en_cnt < n; t++) @(negedge clock);
        if (en_cnt < n) check("bits_timeout", 32'(en_cnt), 32'(n));
        tick();
    endtask

    task automatic run_nominal(input string tag);
        begin_run();
        feed(26, 0);
        check({tag, "_ready_after_last"}, 32'(bif.byte_ready), 32'd0);
        wait_idle(tag, 400);
        check({tag, "_en_cycles"}, 32'(en_cnt), 32'(PB));
        check({tag, "_contiguous"}, 32'(rises), 32'd1);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send13(input logic [7:0] b);
        int t;
        logic ok;
        bif13.byte_data  = b;
        bif13.byte_valid = 1'b1;
        for (t = 0; t < 60; t++) begin
            ok = bif13.byte_ready;
            tick();
            if (ok) break;
        end
        if (t >= 60) check("accept13_timeout", 32'd0, 32'd1);
        bif13.byte_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] img13;
        bif.byte_valid = 1'b0;   bif.byte_data = '0;
        bif13.byte_valid = 1'b0; bif13.byte_data = '0;
        repeat (3) tick();

        // Reset state
        check("rst_prog_enable", 32'(prog_enable), 32'd0);
        check("rst_prog_data", 32'(prog_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_byte_ready", 32'(bif.byte_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        run_nominal("nominal");

        // PREFILL backpressure, plus a start pulse mid-stream that must be ignored
        begin_run();
        fork
            feed(26, 1);
            begin
                wait_bits(30);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        join
        wait_idle("backpressure", 400);
        check("bp_en_cycles", 32'(en_cnt), 32'(PB));
        check("bp_contiguous", 32'(rises), 32'd1);
        check("bp_done_pulses", 32'(done_cnt), 32'd1);
        check("bp_error", 32'(error), 32'd0);

        // Underrun: host supplies bytes 0..10 only
        begin_run();
        feed(11, 0);
        wait_idle("underrun", 400);
        check("ur_en_cycles", 32'(en_cnt), 32'd88);
        check("ur_leftover", 32'(exp_q.size()), 32'd0);
        check("ur_error", 32'(error), 32'd1);
        check("ur_done_pulses", 32'(done_cnt), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ur_start_clears_error", 32'(error), 32'd0);
        check("ur_restart_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ur_abort_idle", 32'(busy), 32'd0);

        // Abort at bit 50
        begin_run();
        fork
            feed(26, 0);
            begin
                wait_bits(50);
                stop_host = 1'b1;
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_prog_enable", 32'(prog_enable), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_error", 32'(error), 32'd0);
            end
        join
        repeat (2) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        exp_q.delete();
        run_nominal("after_abort");

        // Reset mid-SHIFT
        begin_run();
        fork
            feed(26, 0);
            begin
                wait_bits(20);
                stop_host = 1'b1;
                rst_n = 1'b0;
                tick();
                check("midrst_prog_enable", 32'(prog_enable), 32'd0);
                check("midrst_prog_data", 32'(prog_data), 32'd0);
                check("midrst_busy", 32'(busy), 32'd0);
                check("midrst_done", 32'(done), 32'd0);
                check("midrst_error", 32'(error), 32'd0);
                check("midrst_byte_ready", 32'(bif.byte_ready), 32'd0);
                rst_n = 1'b1;
            end
        join
        exp_q.delete();
        tick();

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_state", 32'(state_dbg), 32'd0);
        tick();
        check("start_abort_stays", 32'(busy), 32'd0);

        // Partial last byte on the 13-bit instance
        img13 = 16'hA5FF;
        for (int k = 0; k < PB13; k++) exp13_q.push_back(img13[k]);
        en13 = 0; done13_cnt = 0;
        start13 = 1'b1;
        tick();
        start13 = 1'b0;
        send13(8'hFF);
        send13(8'hA5);
        for (int t = 0; t < 100 && busy13; t++) tick();
        check("p13_idle", 32'(busy13), 32'd0);
        repeat (2) tick();
        check("p13_en_cycles", 32'(en13), 32'(PB13));
        check("p13_done_pulses", 32'(done13_cnt), 32'd1);
        check("p13_leftover", 32'(exp13_q.size()), 32'd0);
        check("p13_error", 32'(error13), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
